// File: rtl/bus_master_arbiter_if.sv
// Signal bundle between the bus arbiter, its two masters and the RAM bus.
// The tri-state data lines are not part of the bundle; they are a plain
// inout port on the arbiter so they can be resolved as a wired net.
interface bus_master_arbiter_if;
    logic       m0_req;
    logic       m0_we;
    logic [7:0] m0_addr;
    logic [7:0] m0_wdata;
    logic       m0_ack;
    logic [7:0] m0_rdata;

    logic       m1_req;
    logic       m1_we;
    logic [7:0] m1_addr;
    logic [7:0] m1_wdata;
    logic       m1_ack;
    logic [7:0] m1_rdata;

    logic [7:0] bus_addr;
    logic       bus_we;
    logic       busy;
    logic       gnt_id;

    // Arbiter side: owns the bus and the acknowledge/return-data path.
    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output bus_addr, bus_we, busy, gnt_id
    );

    // Requesting masters and the RAM/peripheral bus.
    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  bus_addr, bus_we, busy, gnt_id
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Two-master arbiter for the shared 8-bit RAM bus. Grants one transaction
// at a time, sequences write and read timing, and returns read data to
// the granted master. It is the only driver of the bus.
module bus_master_arbiter #(
    parameter logic [7:0]  IDLE_ADDR = 8'hFF,
    parameter int unsigned RD_WAIT   = 1,
    parameter bit          FAIR      = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    bus_master_arbiter_if.master  bus,
    inout  wire  [7:0]            bus_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_t           state;
    state_t           state_next;
    logic             winner;
    logic             start;
    logic             sel_we;
    logic [7:0]       sel_addr;
    logic [7:0]       sel_wdata;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata0;
    logic [7:0]       rdata1;
    logic [7:0]       bus_addr_q;
    logic             bus_we_q;
    logic             ack0;
    logic             ack1;
    logic             gnt;
    logic             rr_favour;
    logic [CNT_W-1:0] cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Winner selection and next-state decode
    always_comb begin
        winner     = 1'b0;
        start      = 1'b0;
        state_next = state;
        if (bus.m0_req && bus.m1_req) winner = FAIR ? rr_favour : 1'b0;
        else                          winner = bus.m1_req;
        sel_we    = winner ? bus.m1_we    : bus.m0_we;
        sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
        case (state)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    start      = 1'b1;
                    state_next = sel_we ? S_WR : S_RD_ADDR;
                end
            end
            S_WR:      state_next = S_IDLE;
            S_RD_ADDR: state_next = S_RD_WAIT;
            S_RD_WAIT: if (cnt == '0) state_next = S_RD_DONE;
            S_RD_DONE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Bus address/strobe, command latch, wait counter, ACK and read data.
    // ACK is registered on entry to WR/RD_DONE so it is high exactly for
    // those one-cycle states.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_addr_q <= IDLE_ADDR;
            bus_we_q   <= 1'b0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            gnt        <= 1'b0;
            rr_favour  <= 1'b0;
            cnt        <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        gnt        <= winner;
                        rr_favour  <= ~winner;
                        bus_addr_q <= sel_addr;
                        bus_we_q   <= sel_we;
                        wdata_q    <= sel_wdata;
                        if (sel_we) begin
                            if (winner) ack1 <= 1'b1;
                            else        ack0 <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    bus_we_q   <= 1'b0;
                    bus_addr_q <= IDLE_ADDR;
                end
                S_RD_ADDR: cnt <= CNT_W'(RD_WAIT - 1);
                S_RD_WAIT: begin
                    if (cnt == '0) begin
                        if (gnt) begin
                            rdata1 <= bus_data;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= bus_data;
                            ack0   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RD_DONE: bus_addr_q <= IDLE_ADDR;
                default: ;
            endcase
        end
    end

    assign bus_data     = (state == S_WR) ? wdata_q : 'z;
    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_we   = bus_we_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.gnt_id   = gnt;
    assign bus.m0_ack   = ack0;
    assign bus.m1_ack   = ack1;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: three instances (round-robin RD_WAIT=1,
// fixed priority RD_WAIT=1, round-robin RD_WAIT=3), each with its own RAM.
// Directed commands feed two master drivers; expected ACKs are queued in
// order and a monitor pops one per ACK of the selected instance.
`timescale 1ns/1ps
module tb_bus_master_arbiter;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int unsigned lat;
    } cmd_t;

    typedef struct {
        logic       m;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] rdata;
        logic [7:0] other;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] we = '0;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    int         sel = 0;
    int         n_vec = 0;
    int         n_err = 0;
    cmd_t       cmdq0[$];
    cmd_t       cmdq1[$];
    exp_t       expq[$];

    always #5 clk = ~clk;

    wire        ack0_v [3];
    wire        ack1_v [3];
    wire [7:0]  rd0_v [3];
    wire [7:0]  rd1_v [3];
    wire [7:0]  baddr_v [3];
    wire        bwe_v [3];
    wire        busy_v [3];
    wire        gnt_v [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam bit          FAIR_G = (g == 1) ? 1'b0 : 1'b1;
        localparam int unsigned RDW_G  = (g == 2) ? 3 : 1;
        bus_master_arbiter_if bif ();
        wire [7:0]  bus_data;
        logic [7:0] mem [256];

        assign bif.m0_req   = req[0];
        assign bif.m0_we    = we[0];
        assign bif.m0_addr  = addr[0];
        assign bif.m0_wdata = wdata[0];
        assign bif.m1_req   = req[1];
        assign bif.m1_we    = we[1];
        assign bif.m1_addr  = addr[1];
        assign bif.m1_wdata = wdata[1];

        bus_master_arbiter #(
            .IDLE_ADDR (8'hFF),
            .RD_WAIT   (RDW_G),
            .FAIR      (FAIR_G)
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .bus      (bif.master),
            .bus_data (bus_data)
        );

        // Asynchronous-read, synchronous-write RAM on the shared bus
        assign bus_data = bif.bus_we ? 'z : mem[bif.bus_addr];
        initial begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h20] <= 8'hC3;
        end
        always @(posedge clk) if (bif.bus_we) mem[bif.bus_addr] <= bus_data;

        assign ack0_v[g]  = bif.m0_ack;
        assign ack1_v[g]  = bif.m1_ack;
        assign rd0_v[g]   = bif.m0_rdata;
        assign rd1_v[g]   = bif.m1_rdata;
        assign baddr_v[g] = bif.bus_addr;
        assign bwe_v[g]   = bif.bus_we;
        assign busy_v[g]  = bif.busy;
        assign gnt_v[g]   = bif.gnt_id;
    end

    logic [1:0] ack_sel;
    logic [7:0] rd_sel [2];
    logic [7:0] baddr_sel;
    logic       bwe_sel, busy_sel, gnt_sel;
    assign ack_sel   = {ack1_v[sel], ack0_v[sel]};
    assign rd_sel[0] = rd0_v[sel];
    assign rd_sel[1] = rd1_v[sel];
    assign baddr_sel = baddr_v[sel];
    assign bwe_sel   = bwe_v[sel];
    assign busy_sel  = busy_v[sel];
    assign gnt_sel   = gnt_v[sel];

    function automatic void push_cmd(input int m, input logic w, input logic [7:0] a,
                                     input logic [7:0] d, input int unsigned lat);
        cmd_t c;
        c.we = w; c.addr = a; c.wdata = d; c.lat = lat;
        if (m == 0) cmdq0.push_back(c);
        else        cmdq1.push_back(c);
    endfunction

    function automatic void push_exp(input logic m, input logic wr, input logic [7:0] a,
                                     input logic [7:0] r, input logic [7:0] o);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = a; e.rdata = r; e.other = o;
        expq.push_back(e);
    endfunction

    // Monitor: one comparison per ACK seen on the selected instance
    always @(negedge clk) begin
        exp_t e;
        int   m;
        if (ack_sel == 2'b11) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_overlap: both ACKs high at %0t, required at most one", $time);
        end else if (ack_sel != 2'b00) begin
            m = ack_sel[1] ? 1 : 0;
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: m%0d ACK at %0t, required none", m, $time);
            end else begin
                e = expq.pop_front();
                if (m != int'(e.m) || rd_sel[m] != e.rdata || rd_sel[1-m] != e.other ||
                    gnt_sel != e.m || !busy_sel || bwe_sel != e.wr || baddr_sel != e.addr) begin
                    n_err++;
                    $display("FAIL ack_check: got m%0d rdata=%h other=%h gnt=%0d busy=%0d we=%0d addr=%h, want m%0d rdata=%h other=%h gnt=%0d busy=1 we=%0d addr=%h",
                             m, rd_sel[m], rd_sel[1-m], gnt_sel, busy_sel, bwe_sel, baddr_sel,
                             e.m, e.rdata, e.other, e.m, e.wr, e.addr);
                end
            end
        end
    end

    // One master: issues its queued commands, holding REQ between them
    task automatic drive_master(input int m);
        cmd_t        c;
        int unsigned cyc;
        bit          more;
        more = (m == 0) ? (cmdq0.size() > 0) : (cmdq1.size() > 0);
        while (more) begin
            if (m == 0) c = cmdq0.pop_front();
            else        c = cmdq1.pop_front();
            we[m] = c.we; addr[m] = c.addr; wdata[m] = c.wdata; req[m] = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ack_sel[m] && cyc < 60);
            if (!ack_sel[m]) begin
                n_vec++;
                n_err++;
                $display("FAIL m%0d_ack_timeout: no ACK within %0d cycles, required ACK", m, cyc);
                req[m] = 1'b0;
                return;
            end
            if (c.lat != 0) begin
                n_vec++;
                if (cyc != c.lat) begin
                    n_err++;
                    $display("FAIL m%0d_latency addr=%h: got %0d cycles, want %0d", m, c.addr, cyc, c.lat);
                end
            end
            @(posedge clk); #1;
            more = (m == 0) ? (cmdq0.size() > 0) : (cmdq1.size() > 0);
            if (!more) req[m] = 1'b0;
        end
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (busy_sel || bwe_sel || baddr_sel != 8'hFF || ack_sel != 2'b00 || gnt_sel ||
            rd_sel[0] != 8'h00 || rd_sel[1] != 8'h00) begin
            n_err++;
            $display("FAIL %s: busy=%0d we=%0d addr=%h ack=%b gnt=%0d rd0=%h rd1=%h, want 0 0 ff 00 0 00 00",
                     name, busy_sel, bwe_sel, baddr_sel, ack_sel, gnt_sel, rd_sel[0], rd_sel[1]);
        end
    endtask

    task automatic do_reset(input int s);
        sel = s;
        req = '0;
        resetn = 1'b0;
        cmdq0.delete(); cmdq1.delete(); expq.delete();
        repeat (2) @(posedge clk);
        #1;
        check_idle($sformatf("reset_dut%0d", s));
        resetn = 1'b1;
    endtask

    task automatic run_phase(input string name);
        fork
            drive_master(0);
            drive_master(1);
        join
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL %s_leftover: %0d expected ACKs never seen, want 0", name, expq.size());
        end
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Write then read back on M0, with latency checks
        do_reset(0);
        push_cmd(0, 1'b1, 8'h10, 8'h5A, 2);
        push_cmd(0, 1'b0, 8'h10, 8'h00, 4);
        push_exp(1'b0, 1'b1, 8'h10, 8'h00, 8'h00);
        push_exp(1'b0, 1'b0, 8'h10, 8'h5A, 8'h00);
        run_phase("m0_wr_rd");

        // M1 read of preloaded 0x20 interleaved with M0 write/read of 0x21
        do_reset(0);
        push_cmd(0, 1'b1, 8'h21, 8'h77, 0);
        push_cmd(0, 1'b0, 8'h21, 8'h00, 0);
        push_cmd(1, 1'b0, 8'h20, 8'h00, 0);
        push_exp(1'b0, 1'b1, 8'h21, 8'h00, 8'h00);
        push_exp(1'b1, 1'b0, 8'h20, 8'hC3, 8'h00);
        push_exp(1'b0, 1'b0, 8'h21, 8'h77, 8'hC3);
        run_phase("mixed");

        // Round-robin with both requests held: strict alternation
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'b1, 8'(8'h30 + i), 8'(i + 1), 0);
            push_cmd(1, 1'b0, 8'h20, 8'h00, 0);
            push_exp(1'b0, 1'b1, 8'(8'h30 + i), 8'h00, (i == 0) ? 8'h00 : 8'hC3);
            push_exp(1'b1, 1'b0, 8'h20, 8'hC3, 8'h00);
        end
        run_phase("fair");

        // Fixed priority: M1 waits until M0 drops its request
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            push_cmd(0, 1'b1, 8'(8'h60 + i), 8'(8'h0A + i), 0);
            push_exp(1'b0, 1'b1, 8'(8'h60 + i), 8'h00, 8'h00);
        end
        push_cmd(1, 1'b0, 8'h20, 8'h00, 0);
        push_exp(1'b1, 1'b0, 8'h20, 8'hC3, 8'h00);
        run_phase("fixed");

        // RD_WAIT=3 latency
        do_reset(2);
        push_cmd(0, 1'b1, 8'h50, 8'hA5, 2);
        push_cmd(0, 1'b0, 8'h50, 8'h00, 6);
        push_exp(1'b0, 1'b1, 8'h50, 8'h00, 8'h00);
        push_exp(1'b0, 1'b0, 8'h50, 8'hA5, 8'h00);
        run_phase("rdwait3");

        // Reset in the middle of RD_WAIT drops the read without an ACK
        do_reset(2);
        we[0] = 1'b0; addr[0] = 8'h20; req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (!busy_sel) begin
            n_err++;
            $display("FAIL busy_mid_read: got busy=%0d, want 1", busy_sel);
        end
        resetn = 1'b0;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_mid_rd_wait");
        resetn = 1'b1;
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
